// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Two-way round-robin arbiter that shares the single register-file write port
// between the vector ALU pipe (requester 0) and the memory load unit
// (requester 1). The winning request is captured in a one-stage output
// register, and that register drives the register file directly. A saturating
// counter records how many cycles both requesters contended while not stalled.

module reg_write_arbiter #(
  parameter int registerSize  = 16,
  parameter int vectorSize    = 4,
  parameter int selectionBits = 3,
  parameter int counterWidth  = 16
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [1:0]                                    reqValid,
  output logic [1:0]                                    reqReady,
  input  logic [1:0]                                    reqScalar,
  input  logic [1:0][selectionBits-1:0]                 reqReg,
  input  logic [1:0][vectorSize-1:0][registerSize-1:0]  reqData,
  input  logic                                          stall,
  output logic                                          regWrEnSc,
  output logic                                          regWrEnVec,
  output logic [selectionBits-1:0]                      regToWrite,
  output logic [vectorSize-1:0][registerSize-1:0]       dataIn,
  output logic                                          lastGrant,
  output logic [counterWidth-1:0]                       conflictCount
);

  localparam logic [counterWidth-1:0] cnt_one = {{(counterWidth-1){1'b0}}, 1'b1};

  // Index of the requester that wins when both requesters are valid.
  logic prio;

  logic handshake;
  logic win_idx;
  logic contention;

  // Grant decode. It depends only on valid, stall, prio and reset, so there is
  // no path from the request payload to the ready signals. Reset forces the
  // grants low so that no handshake is seen while the block is held in reset.
  always_comb begin
    reqReady = 2'b00;
    if (reset && !stall) begin
      unique case (reqValid)
        2'b01:   reqReady = 2'b01;
        2'b10:   reqReady = 2'b10;
        2'b11:   reqReady = prio ? 2'b10 : 2'b01;
        default: reqReady = 2'b00;
      endcase
    end
  end

  // At most one ready bit is ever set, so the winner is simply ready[1].
  assign handshake  = |(reqValid & reqReady);
  assign win_idx    = reqReady[1];
  assign contention = (reqValid == 2'b11) && !stall;

  // Output stage. The enables pulse for one cycle per handshake. Address,
  // data and last-grant hold their values between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      regToWrite <= '0;
      dataIn     <= '0;
      lastGrant  <= 1'b0;
    end else if (handshake) begin
      regWrEnSc  <= reqScalar[win_idx];
      regWrEnVec <= ~reqScalar[win_idx];
      regToWrite <= reqReg[win_idx];
      dataIn     <= reqData[win_idx];
      lastGrant  <= win_idx;
    end else begin
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
    end
  end

  // Round-robin pointer: after each grant, the loser gets priority next time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (handshake) begin
      prio <= ~win_idx;
    end
  end

  // Conflict counter. It saturates at all-ones and does not wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflictCount <= '0;
    end else if (contention && !(&conflictCount)) begin
      conflictCount <= conflictCount + cnt_one;
    end
  end

endmodule
